mcycle_ctrl: RTL
================

Name: mcycle_ctrl

Overview:
Issue/sequencing controller between the Execute stage and the shared multi-cycle multiply/divide unit (MCycle). It accepts one RV32M operation (funct3) per handshake and decodes it to an MCycleOp. It launches the unit with a one-cycle Start pulse, waits out Busy, then selects and post-processes Result1/Result2. Div-by-zero and signed-overflow cases are resolved locally without launching. MULHSU is synthesised from an unsigned multiply plus sign fix-up.

Parameters:
WIDTH, 32, operand/result width; must match MCycle width.
TAG_W, 5, width of the opaque tag carried from request to response (e.g. rd index).

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
req_rs1  in  WIDTH  operand 1 (dividend/multiplicand)
req_rs2  in  WIDTH  operand 2 (divisor/multiplier)
req_tag  in  TAG_W  returned with result
resp_valid  out  1  result present, held until accepted
resp_ready  in  1  consumer accepts
resp_data  out  WIDTH  result word
resp_tag  out  TAG_W  tag of the request
mc_start  out  1  Start to MCycle, one-cycle pulse
mc_op  out  2  MCycleOp: 00 mul s, 01 mul u, 10 div s, 11 div u
mc_operand1  out  WIDTH  Operand1 to MCycle, registered
mc_operand2  out  WIDTH  Operand2 to MCycle, registered
mc_result1  in  WIDTH  MCycle LSW/quotient
mc_result2  in  WIDTH  MCycle MSW/remainder
mc_busy  in  1  MCycle Busy, combinational from MCycle

Behaviour:
- Clocking/reset: one clock CLK; reset is synchronous, active-low (RESETn).
- Reset values: state IDLE; resp_valid=0, mc_start=0, mc_op=0, mc_operand1/2=0, resp_data=0, resp_tag=0.
- req_ready = (state==IDLE) & ~mc_busy. Accept = req_valid & req_ready. Single outstanding operation.
- States:
  - IDLE: on accept, latch funct3, rs1, rs2 and tag.
    - Fast-path condition true: go RESP with result computed.
    - Otherwise: go LAUNCH.
  - LAUNCH: mc_start=1 for exactly this cycle; mc_op and operands are stable from this cycle until the result is captured. Next state is WAIT.
  - WAIT: when mc_busy==0, capture and post-process results, then go RESP. While mc_busy==1, stay.
  - RESP: resp_valid=1; resp_data and resp_tag are stable. When resp_ready=1, go IDLE.
- Decode (op, word selected):
  - MUL: 00, R1. MULH: 00, R2. MULHU: 01, R2.
  - DIV: 10, R1. REM: 10, R2. DIVU: 11, R1. REMU: 11, R2.
- MULHSU: op 01 with operand1 = rs1[MSB] ? -rs1 : rs1, operand2 = rs2.
  - If rs1 was negative: result = ~R2 + (R1==0).
  - Otherwise: result = R2.
  - rs1=0x80000000 negates to itself and is correct as unsigned 2^31.
- Fast path (no launch, mc_start never asserted):
  - rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1==0x80..0 & rs2==all-ones) for DIV/REM: DIV gives 0x80..0; REM gives 0.
- Latency, accept at cycle N:
  - Fast path: resp_valid at N+1.
  - Launched op: mc_start at N+1; resp_valid one cycle after the first WAIT cycle with mc_busy==0.
- Backpressure: resp_valid and resp_data hold indefinitely while resp_ready=0; req_ready is 0 during that time.
- Reset mid-operation: state returns to IDLE and any in-flight result is discarded. If MCycle is still busy, req_ready stays 0 until mc_busy falls, so a new request never overlaps a stale computation.
- Unused funct3: none; all 8 encodings are defined.

Optional Feature:
Macro MCYCLE_CTRL_REUSE_EN.
- Defined: the controller keeps the last captured {mc_op, operand1, operand2, R1, R2} plus a valid bit.
  - A request whose decoded op and effective operands match a valid entry skips launch; resp_valid appears at N+1 with the selected word, post-processed as normal. This covers pairs such as MULH→MUL and DIV→REM.
  - Fast-path requests never update the entry.
  - The valid bit clears on reset.
- Undefined: no storage; every non-fast-path request launches MCycle.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → single mc_start with mc_op=00; resp_data=0xFFFFFFEB; tag echoed.
- MULHSU rs1=0xFFFFFFFF, rs2=2 → mc_op=01, mc_operand1=1; resp_data=0xFFFFFFFF. MULHU with the same operands → 0x00000001.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → resp_data=0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. All four: resp_valid exactly 1 cycle after accept, mc_start stays 0.
- MUL 3*4 with resp_ready held 0 for 5 cycles → resp_data=12 stable; resp_valid=1; req_ready=0 throughout; after resp_ready, req_ready=1 the following cycle.
- Assert RESETn=0 for 1 cycle while in WAIT → resp_valid=0 and state IDLE. req_ready stays 0 until mc_busy falls; the next request MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.

Source files
------------

// File: rtl/mcycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_ctrl
// Description : Issue/sequencing controller between Execute and the shared
//               multi-cycle multiply/divide unit (MCycle). Accepts one RV32M
//               operation per handshake, launches MCycle with a one-cycle
//               Start pulse, waits out Busy, then selects and post-processes
//               Result1/Result2. Divide-by-zero and signed overflow resolve
//               locally. MULHSU is built from an unsigned multiply plus a
//               sign fix-up.
// Ports       : CLK, RESETn (sync, active-low)
//               req_*  : request handshake (funct3, rs1, rs2, tag)
//               resp_* : response handshake (data, tag)
//               mc_*   : MCycle interface (start, op, operands, results, busy)
// Options     : MCYCLE_CTRL_REUSE_EN - keep the last MCycle result and answer
//               matching requests (e.g. MULH->MUL, DIV->REM) without launch.
// Revision    : 1.0 - initial release
// ============================================================================
module mcycle_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_rs1,
    input  logic [WIDTH-1:0] req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             mc_start,
    output logic [1:0]       mc_op,
    output logic [WIDTH-1:0] mc_operand1,
    output logic [WIDTH-1:0] mc_operand2,
    input  logic [WIDTH-1:0] mc_result1,
    input  logic [WIDTH-1:0] mc_result2,
    input  logic             mc_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [WIDTH-1:0] c_MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_sel_r2;
    logic             r_fix;
    logic [1:0]       r_mc_op;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_resp_data;
    logic [TAG_W-1:0] r_resp_tag;

    // Word selection plus MULHSU fix-up: high word of -(|rs1| * rs2) is
    // ~R2 plus a carry that only propagates when the low word is zero.
    function automatic logic [WIDTH-1:0] post_proc(
        input logic [WIDTH-1:0] r1,
        input logic [WIDTH-1:0] r2,
        input logic             sel_r2,
        input logic             fix
    );
        logic [WIDTH-1:0] v;
        if (fix)
            v = ~r2 + {{(WIDTH-1){1'b0}}, (r1 == '0)};
        else
            v = sel_r2 ? r2 : r1;
        return v;
    endfunction

    // ---------------- request decode ----------------
    logic             w_accept;
    logic             w_is_div;
    logic             w_is_rem;
    logic             w_rs2_zero;
    logic             w_ovf;
    logic             w_fast;
    logic [WIDTH-1:0] w_fast_data;
    logic [1:0]       w_op;
    logic             w_sel_r2;
    logic             w_fix;
    logic [WIDTH-1:0] w_op1;
    logic             w_hit;
    logic [WIDTH-1:0] w_hit_data;

    assign w_accept   = req_valid & req_ready;
    assign w_is_div   = req_funct3[2];
    assign w_is_rem   = req_funct3[1];
    assign w_rs2_zero = (req_rs2 == '0);
    // funct3[0]==0 marks the signed divide flavours (DIV/REM)
    assign w_ovf      = w_is_div & ~req_funct3[0] & (req_rs1 == c_MIN_INT) & (req_rs2 == '1);
    assign w_fast     = w_is_div & (w_rs2_zero | w_ovf);
    assign w_op       = req_funct3[2] ? {1'b1, req_funct3[0]} : {1'b0, req_funct3[1]};
    assign w_sel_r2   = req_funct3[2] ? req_funct3[1] : (req_funct3[1:0] != 2'b00);
    assign w_fix      = (req_funct3 == 3'b010) & req_rs1[WIDTH-1];
    // MIN_INT negates to itself, which is the correct unsigned magnitude
    assign w_op1      = w_fix ? ('0 - req_rs1) : req_rs1;

    always_comb begin
        w_fast_data = '0;
        if (w_rs2_zero)
            w_fast_data = w_is_rem ? req_rs1 : '1;
        else
            w_fast_data = w_is_rem ? '0 : c_MIN_INT;
    end

`ifdef MCYCLE_CTRL_REUSE_EN
    logic             r_c_valid;
    logic [1:0]       r_c_op;
    logic [WIDTH-1:0] r_c_op1;
    logic [WIDTH-1:0] r_c_op2;
    logic [WIDTH-1:0] r_c_r1;
    logic [WIDTH-1:0] r_c_r2;

    assign w_hit      = ~w_fast & r_c_valid & (r_c_op == w_op) &
                        (r_c_op1 == w_op1) & (r_c_op2 == req_rs2);
    assign w_hit_data = post_proc(r_c_r1, r_c_r2, w_sel_r2, w_fix);

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_c_valid <= 1'b0;
            r_c_op    <= '0;
            r_c_op1   <= '0;
            r_c_op2   <= '0;
            r_c_r1    <= '0;
            r_c_r2    <= '0;
        end else if (r_state == S_WAIT && !mc_busy) begin
            r_c_valid <= 1'b1;
            r_c_op    <= r_mc_op;
            r_c_op1   <= r_op1;
            r_c_op2   <= r_op2;
            r_c_r1    <= mc_result1;
            r_c_r2    <= mc_result2;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = (w_fast | w_hit) ? S_RESP : S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT:   if (!mc_busy) w_state_nxt = S_RESP;
            S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Holding off while MCycle is busy keeps a request issued after a
    // mid-operation reset from overlapping the stale computation.
    always_comb begin
        req_ready  = (r_state == S_IDLE) & ~mc_busy;
        mc_start   = (r_state == S_LAUNCH);
        resp_valid = (r_state == S_RESP);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_sel_r2    <= 1'b0;
            r_fix       <= 1'b0;
            r_mc_op     <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_resp_data <= '0;
            r_resp_tag  <= '0;
        end else begin
            if (r_state == S_IDLE && w_accept) begin
                r_resp_tag <= req_tag;
                if (w_fast || w_hit) begin
                    r_resp_data <= w_fast ? w_fast_data : w_hit_data;
                end else begin
                    r_sel_r2 <= w_sel_r2;
                    r_fix    <= w_fix;
                    r_mc_op  <= w_op;
                    r_op1    <= w_op1;
                    r_op2    <= req_rs2;
                end
            end
            if (r_state == S_WAIT && !mc_busy)
                r_resp_data <= post_proc(mc_result1, mc_result2, r_sel_r2, r_fix);
        end
    end

    assign mc_op       = r_mc_op;
    assign mc_operand1 = r_op1;
    assign mc_operand2 = r_op2;
    assign resp_data   = r_resp_data;
    assign resp_tag    = r_resp_tag;

endmodule
`default_nettype wire
